// File: rtl/spi_reg_file_pkg.sv
// Shared bridge register package: register addresses, CTRL/STATUS bit
// positions and identification defaults. Firmware headers are generated
// from this file, so keep names and values stable.
package spi_reg_file_pkg;

  localparam logic [6:0] ADDR_ID         = 7'h00;
  localparam logic [6:0] ADDR_VERSION    = 7'h01;
  localparam logic [6:0] ADDR_CTRL       = 7'h02;
  localparam logic [6:0] ADDR_STATUS     = 7'h03;
  localparam logic [6:0] ADDR_SCRATCH    = 7'h04;
  localparam logic [6:0] ADDR_FIFO_WDATA = 7'h10;
  localparam logic [6:0] ADDR_FIFO_LEVEL = 7'h11;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_FLUSH_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;

  localparam logic [7:0] ID_DEFAULT      = 8'hB5;
  localparam logic [7:0] VERSION_DEFAULT = 8'h01;

  // CTRL as seen by a read: FLUSH is self-clearing and always reads 0.
  function automatic logic [7:0] pack_ctrl(input logic en, input logic irq_en);
    logic [7:0] v;
    v                  = 8'h00;
    v[CTRL_EN_BIT]     = en;
    v[CTRL_IRQ_EN_BIT] = irq_en;
    return v;
  endfunction

  function automatic logic [7:0] pack_status(input logic empty, input logic full,
                                             input logic ovf);
    logic [7:0] v;
    v                   = 8'h00;
    v[STATUS_EMPTY_BIT] = empty;
    v[STATUS_FULL_BIT]  = full;
    v[STATUS_OVF_BIT]   = ovf;
    return v;
  endfunction

endpackage

// File: rtl/spi_reg_file_mem.sv
// Command FIFO storage: DEPTH x 8 array, synchronous write, asynchronous
// read. No reset so it maps onto distributed RAM.
module cmd_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/spi_reg_file.sv
// SPI-side register file with a transactional command FIFO. Bytes written
// to FIFO_WDATA are staged and only become visible to the HID engine when
// the SPI transaction ends cleanly; any dropped byte discards the whole
// transaction and raises the sticky OVF flag.
module spi_reg_file
  import spi_reg_file_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] ID_VALUE   = ID_DEFAULT,
  parameter logic [7:0] VERSION    = VERSION_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_wen,
  input  logic       reg_ren,
  input  logic       reg_done,
  output logic [7:0] reg_rdata,
  output logic [7:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

  logic          r_en;
  logic          r_irq_en;
  logic          r_ovf;
  logic          r_txn_ovf;
  logic [7:0]    r_scratch;
  logic [7:0]    r_rdata;
  logic          r_irq;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_wr_stage;

  // Upstream has already advanced the address when it strobes a write.
  logic [6:0] w_waddr;
  assign w_waddr = reg_addr - 7'd1;

  logic w_wr_ctrl, w_wr_status, w_wr_scratch, w_wr_fifo, w_flush;
  assign w_wr_ctrl    = reg_wen && (w_waddr == ADDR_CTRL);
  assign w_wr_status  = reg_wen && (w_waddr == ADDR_STATUS);
  assign w_wr_scratch = reg_wen && (w_waddr == ADDR_SCRATCH);
  assign w_wr_fifo    = reg_wen && (w_waddr == ADDR_FIFO_WDATA);
  assign w_flush      = w_wr_ctrl && reg_wdata[CTRL_FLUSH_BIT];

  // Pointer arithmetic wraps naturally at 2*FIFO_DEPTH via the PW width.
  logic [PW-1:0] w_level, w_stage_used, w_stage_nxt;
  logic          w_empty, w_full, w_space_ok, w_push, w_drop, w_pop;
  logic          w_txn_ovf_nxt, w_commit, w_discard;
  assign w_level      = r_wr_ptr - r_rd_ptr;
  assign w_stage_used = r_wr_stage - r_rd_ptr;
  assign w_empty      = (w_level == '0);
  assign w_full       = (w_level == DEPTH_P);
  assign w_space_ok   = (w_stage_used < DEPTH_P);
  assign w_push       = w_wr_fifo && w_space_ok;
  assign w_drop       = w_wr_fifo && !w_space_ok;
  assign cmd_valid    = r_en && !w_empty;
  assign w_pop        = cmd_valid && cmd_ready;

  // A write landing in the same cycle as reg_done belongs to the ending
  // transaction, so commit/discard act on the post-push stage state.
  assign w_stage_nxt   = w_push ? (r_wr_stage + PW'(1)) : r_wr_stage;
  assign w_txn_ovf_nxt = r_txn_ovf || w_drop;
  assign w_commit      = reg_done && !w_txn_ovf_nxt;
  assign w_discard     = reg_done && w_txn_ovf_nxt;

  cmd_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_stage[AW-1:0]),
    .i_wdata (reg_wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (cmd_data)
  );

  // FIFO pointers and per-transaction overflow tracking; FLUSH wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_wr_stage <= '0;
      r_txn_ovf  <= 1'b0;
    end else if (w_flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_wr_stage <= '0;
      r_txn_ovf  <= 1'b0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_discard) begin
        r_wr_stage <= r_wr_ptr;
        r_txn_ovf  <= 1'b0;
      end else begin
        r_wr_stage <= w_stage_nxt;
        r_txn_ovf  <= w_txn_ovf_nxt;
      end
      if (w_commit) r_wr_ptr <= w_stage_nxt;
    end
  end

  // CTRL, SCRATCH and the sticky OVF flag (setting beats a W1C clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_scratch <= 8'h00;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= reg_wdata[CTRL_EN_BIT];
        r_irq_en <= reg_wdata[CTRL_IRQ_EN_BIT];
      end
      if (w_wr_scratch) r_scratch <= reg_wdata;
      if (w_discard && !w_flush) r_ovf <= 1'b1;
      else if (w_wr_status && reg_wdata[STATUS_OVF_BIT]) r_ovf <= 1'b0;
    end
  end

  // Interrupt is a registered copy of IRQ_EN & OVF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= r_irq_en && r_ovf;
  end

  // Read mux; every source is a plain view of state, so prefetch is harmless.
  logic [7:0] w_rd_mux;
  always_comb begin
    w_rd_mux = 8'h00;
    case (reg_addr)
      ADDR_ID:         w_rd_mux = ID_VALUE;
      ADDR_VERSION:    w_rd_mux = VERSION;
      ADDR_CTRL:       w_rd_mux = pack_ctrl(r_en, r_irq_en);
      ADDR_STATUS:     w_rd_mux = pack_status(w_empty, w_full, r_ovf);
      ADDR_SCRATCH:    w_rd_mux = r_scratch;
      ADDR_FIFO_LEVEL: w_rd_mux = 8'(w_level);
      default:         w_rd_mux = 8'h00;
    endcase
  end

  // Read data is captured only on a fetch strobe and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rdata <= 8'h00;
    else if (reg_ren) r_rdata <= w_rd_mux;
  end

  assign reg_rdata = r_rdata;
  assign irq       = r_irq;

endmodule

// File: tb/tb_spi_reg_file.sv
// Bench for spi_reg_file: queue-based behavioural model plus a per-cycle
// compare process, directed scenarios with literal expectations, then a
// randomized register/FIFO traffic phase.
module tb_spi_reg_file;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0;
  logic       reg_wen = 1'b0, reg_ren = 1'b0, reg_done = 1'b0, cmd_ready = 1'b0;
  logic [7:0] reg_rdata, cmd_data;
  logic       cmd_valid, irq;

  spi_reg_file #(
    .FIFO_DEPTH (DEPTH),
    .ID_VALUE   (8'hB5),
    .VERSION    (8'h01)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wen   (reg_wen),
    .reg_ren   (reg_ren),
    .reg_done  (reg_done),
    .reg_rdata (reg_rdata),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .irq       (irq)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: committed bytes, staged bytes, flags.
  byte unsigned committed[$];
  byte unsigned staged[$];
  bit           m_en, m_irqen, m_ovf, m_txn, m_irq;
  byte unsigned m_scratch, m_rdata;

  function automatic void model_reset();
    committed.delete();
    staged.delete();
    m_en = 0; m_irqen = 0; m_ovf = 0; m_txn = 0; m_irq = 0;
    m_scratch = 8'h00; m_rdata = 8'h00;
  endfunction

  function automatic byte unsigned model_read(input logic [6:0] a);
    case (a)
      7'h00:   return 8'hB5;
      7'h01:   return 8'h01;
      7'h02:   return {5'b0, m_irqen, 1'b0, m_en};
      7'h03:   return {5'b0, m_ovf, committed.size() == DEPTH, committed.size() == 0};
      7'h04:   return m_scratch;
      7'h11:   return 8'(committed.size());
      default: return 8'h00;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_step();
    bit           pop, space, flush, clr, set_ovf;
    byte unsigned rd;
    logic [6:0]   wa;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rd      = model_read(reg_addr);
    pop     = m_en && committed.size() != 0 && cmd_ready;
    space   = (committed.size() + staged.size()) < DEPTH;
    m_irq   = m_irqen && m_ovf;
    flush   = 0; clr = 0; set_ovf = 0;
    wa      = reg_addr - 7'd1;
    if (reg_wen) begin
      case (wa)
        7'h02: begin
          m_en    = reg_wdata[0];
          m_irqen = reg_wdata[2];
          flush   = reg_wdata[1];
        end
        7'h03: clr = reg_wdata[2];
        7'h04: m_scratch = reg_wdata;
        7'h10: begin
          if (space) staged.push_back(reg_wdata);
          else       m_txn = 1;
        end
        default: ;
      endcase
    end
    if (flush) begin
      committed.delete();
      staged.delete();
      m_txn = 0;
    end else begin
      if (pop) void'(committed.pop_front());
      if (reg_done) begin
        if (m_txn) begin
          set_ovf = 1;
          m_txn   = 0;
        end else begin
          foreach (staged[i]) committed.push_back(staged[i]);
        end
        staged.delete();
      end
    end
    if (clr)     m_ovf = 0;
    if (set_ovf) m_ovf = 1;
    if (reg_ren) m_rdata = rd;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = m_en && committed.size() != 0;
      checks++;
      if (cmd_valid !== ev) begin
        errors++;
        $display("FAIL cmd_valid: got %b, expected %b (t=%0t)", cmd_valid, ev, $time);
      end
      if (ev) begin
        checks++;
        if (cmd_data !== committed[0]) begin
          errors++;
          $display("FAIL cmd_data: got %h, expected %h (t=%0t)", cmd_data, committed[0], $time);
        end
      end
      checks++;
      if (reg_rdata !== m_rdata) begin
        errors++;
        $display("FAIL reg_rdata: got %h, expected %h (t=%0t)", reg_rdata, m_rdata, $time);
      end
      checks++;
      if (irq !== m_irq) begin
        errors++;
        $display("FAIL irq: got %b, expected %b (t=%0t)", irq, m_irq, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [6:0] target, input logic [7:0] d);
    reg_addr  = target + 7'd1;
    reg_wdata = d;
    reg_wen   = 1'b1;
    tick();
    reg_wen   = 1'b0;
  endtask

  task automatic rd_chk(input logic [6:0] a, input string name, input logic [7:0] exp);
    reg_addr = a;
    reg_ren  = 1'b1;
    tick();
    reg_ren  = 1'b0;
    check(name, reg_rdata, exp);
  endtask

  task automatic done_pulse();
    reg_done = 1'b1;
    tick();
    reg_done = 1'b0;
  endtask

  initial begin
    int r, ready_pct;
    model_reset();
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("reset_rdata", reg_rdata, 8'h00);
    check("reset_irq", irq, 1'b0);
    check("reset_valid", cmd_valid, 1'b0);

    // ID / VERSION burst, then hold
    reg_addr = 7'h00; reg_ren = 1'b1; tick();
    check("id", reg_rdata, 8'hB5);
    reg_addr = 7'h01; tick();
    check("version", reg_rdata, 8'h01);
    reg_ren = 1'b0; reg_addr = 7'h04; tick();
    check("rdata_hold", reg_rdata, 8'h01);

    // SCRATCH via post-incremented address; unmapped and write-only reads
    reg_addr = 7'h05; reg_wdata = 8'h5A; reg_wen = 1'b1; tick(); reg_wen = 1'b0;
    rd_chk(7'h04, "scratch", 8'h5A);
    rd_chk(7'h7F, "unmapped", 8'h00);
    rd_chk(7'h10, "fifo_wdata_rd", 8'h00);

    // Staged bytes are invisible until commit, then drain in order
    cmd_ready = 1'b0;
    wr(7'h02, 8'h01);
    wr(7'h10, 8'h11);
    wr(7'h10, 8'h22);
    wr(7'h10, 8'h33);
    check("staged_valid", cmd_valid, 1'b0);
    rd_chk(7'h11, "staged_level", 8'h00);
    done_pulse();
    check("commit_valid", cmd_valid, 1'b1);
    check("commit_head", cmd_data, 8'h11);
    rd_chk(7'h11, "commit_level", 8'h03);
    cmd_ready = 1'b1;
    tick(); check("drain1", cmd_data, 8'h22);
    tick(); check("drain2", cmd_data, 8'h33);
    tick(); check("drain_empty", cmd_valid, 1'b0);
    cmd_ready = 1'b0;

    // Overflow discards the whole transaction
    wr(7'h02, 8'h05);
    for (int i = 0; i < 14; i++) wr(7'h10, 8'(8'h40 + i));
    done_pulse();
    rd_chk(7'h11, "level14", 8'h0E);
    wr(7'h10, 8'hA1); wr(7'h10, 8'hA2); wr(7'h10, 8'hA3);
    done_pulse();
    rd_chk(7'h11, "ovf_level", 8'h0E);
    rd_chk(7'h03, "ovf_status", 8'h04);
    check("ovf_irq", irq, 1'b1);
    wr(7'h03, 8'h04);
    rd_chk(7'h03, "ovf_w1c", 8'h00);
    check("irq_clear", irq, 1'b0);

    // Full FIFO, then push/pop and commit/pop overlap, then flush during pop
    wr(7'h10, 8'hB1); wr(7'h10, 8'hB2);
    done_pulse();
    rd_chk(7'h03, "full_status", 8'h02);
    cmd_ready = 1'b1;
    tick();
    wr(7'h10, 8'hC7);
    done_pulse();
    cmd_ready = 1'b0;
    rd_chk(7'h11, "overlap_level", 8'h0E);
    cmd_ready = 1'b1;
    wr(7'h02, 8'h07);
    check("flush_valid", cmd_valid, 1'b0);
    cmd_ready = 1'b0;
    rd_chk(7'h11, "flush_level", 8'h00);
    rd_chk(7'h02, "ctrl_flush_rd0", 8'h05);

    // Reset mid-transaction drops committed and staged bytes
    wr(7'h10, 8'hD1); wr(7'h10, 8'hD2);
    done_pulse();
    wr(7'h10, 8'hD3); wr(7'h10, 8'hD4);
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_rdata", reg_rdata, 8'h00);
    wr(7'h02, 8'h01);
    check("rst_en_valid", cmd_valid, 1'b0);
    rd_chk(7'h11, "rst_level", 8'h00);
    done_pulse();
    check("rst_done_valid", cmd_valid, 1'b0);

    // Randomized traffic, alternating drain-heavy and fill-heavy phases
    for (int n = 0; n < 4000; n++) begin
      ready_pct = ((n / 500) % 2 == 0) ? 75 : 8;
      reg_wen   = 1'b0;
      reg_ren   = 1'b0;
      reg_done  = 1'b0;
      cmd_ready = ($urandom_range(0, 99) < ready_pct);
      r = $urandom_range(0, 99);
      reg_wdata = 8'($urandom);
      if (r < 40) begin
        reg_addr = 7'h11; reg_wen = 1'b1;
      end else if (r < 45) begin
        reg_addr  = 7'h03;
        reg_wdata = {5'b0, 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0)};
        reg_wen   = 1'b1;
      end else if (r < 48) begin
        reg_addr = 7'h04; reg_wen = 1'b1;
      end else if (r < 50) begin
        reg_addr = 7'h05; reg_wen = 1'b1;
      end else if (r < 52) begin
        reg_addr = 7'($urandom); reg_wen = 1'b1;
      end else begin
        case ($urandom_range(0, 7))
          0: reg_addr = 7'h00;
          1: reg_addr = 7'h01;
          2: reg_addr = 7'h02;
          3: reg_addr = 7'h03;
          4: reg_addr = 7'h04;
          5: reg_addr = 7'h10;
          6: reg_addr = 7'h11;
          default: reg_addr = 7'($urandom);
        endcase
      end
      if ($urandom_range(0, 2) == 0) reg_ren = 1'b1;
      if ($urandom_range(0, 7) == 0) reg_done = 1'b1;
      tick();
    end
    reg_wen = 1'b0; reg_ren = 1'b0; reg_done = 1'b0; cmd_ready = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
